// File: rtl/serial_addk.sv
// serial_addk: bit-serial add or subtract of a constant K on LSB-first words.
// S and V are Mealy outputs for the bit currently on X. RESULT, RV and RVALID
// are registered one cycle after the last bit of each word is consumed.
module serial_addk #(
  parameter int WIDTH = 4,
  parameter int K     = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             X,
  input  logic             EN,
  input  logic             MODE,
  output logic             S,
  output logic             V,
  output logic             LAST,
  output logic [WIDTH-1:0] RESULT,
  output logic             RVALID,
  output logic             RV
);

  localparam int              PW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] K_VEC    = WIDTH'(K);
  localparam logic [PW-1:0]    LAST_POS = PW'(WIDTH - 1);

  // Next carry (add) or next borrow (subtract) for one bit position.
  function automatic logic next_carry(input logic x, input logic kb,
                                      input logic c, input logic sub);
    logic r;
    if (sub) begin
      r = (~x & kb) | (~(x ^ kb) & c);
    end else begin
      r = (x & kb) | (x & c) | (kb & c);
    end
    return r;
  endfunction

  logic [PW-1:0]    pos_r;
  logic             c_r;
  logic             mq_r;
  logic [WIDTH-2:0] sr_r;
  logic [WIDTH-1:0] result_r;
  logic             rvalid_r;
  logic             rv_r;

  logic             first_s;
  logic             last_pos_s;
  logic             mode_eff_s;
  logic             cin_s;
  logic             kb_s;
  logic             sum_s;
  logic             cnext_s;
  logic [WIDTH-2:0] sr_next_s;

  // Per-bit datapath: the first bit of a word uses live MODE and a zero carry-in.
  always_comb begin
    first_s    = (pos_r == {PW{1'b0}});
    last_pos_s = (pos_r == LAST_POS);
    mode_eff_s = mq_r;
    cin_s      = c_r;
    if (first_s) begin
      mode_eff_s = MODE;
      cin_s      = 1'b0;
    end else begin
      mode_eff_s = mq_r;
      cin_s      = c_r;
    end
    kb_s      = K_VEC[pos_r];
    sum_s     = X ^ kb_s ^ cin_s;
    cnext_s   = next_carry(X, kb_s, cin_s, mode_eff_s);
    sr_next_s = (WIDTH-1)'({sum_s, sr_r} >> 1);
  end

  // Mealy outputs; while reset is held the block is transparent (S follows X).
  always_comb begin
    S    = X;
    V    = 1'b0;
    LAST = 1'b0;
    if (RST_N) begin
      S    = sum_s;
      LAST = EN & last_pos_s;
      V    = EN & last_pos_s & cnext_s;
    end else begin
      S    = X;
      V    = 1'b0;
      LAST = 1'b0;
    end
  end

  // Bit counter, carry, latched mode, shift register and result capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pos_r    <= {PW{1'b0}};
      c_r      <= 1'b0;
      mq_r     <= 1'b0;
      sr_r     <= {(WIDTH-1){1'b0}};
      result_r <= {WIDTH{1'b0}};
      rvalid_r <= 1'b0;
      rv_r     <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      if (EN) begin
        sr_r <= sr_next_s;
        if (first_s) begin
          mq_r <= MODE;
        end else begin
          mq_r <= mq_r;
        end
        if (last_pos_s) begin
          pos_r    <= {PW{1'b0}};
          c_r      <= 1'b0;
          result_r <= {sum_s, sr_r};
          rv_r     <= cnext_s;
          rvalid_r <= 1'b1;
        end else begin
          pos_r <= pos_r + PW'(1);
          c_r   <= cnext_s;
        end
      end else begin
        pos_r <= pos_r;
        c_r   <= c_r;
      end
    end
  end

  assign RESULT = result_r;
  assign RVALID = rvalid_r;
  assign RV     = rv_r;

endmodule

// File: doc/serial_addk.md
SERIAL_ADDK -- requirements
Module: serial_addk

Interface
REQ-001 Parameter WIDTH, default 4: bits per serial word; legal range 2..16.
REQ-002 Parameter K, default 3: constant applied to each word; legal range 0..2^WIDTH-1.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1: asynchronous, active-low reset.
REQ-005 X  input  1: serial data bit, LSB first.
REQ-006 EN  input  1: qualifies X; a bit is consumed only on a CLK edge with EN=1.
REQ-007 MODE  input  1: 0 = add K, 1 = subtract K; sampled on the first bit of each word only.
REQ-008 S  output  1: combinational serial result bit for the current X (Mealy).
REQ-009 V  output  1: combinational flag, valid on the last bit of a word: carry-out (add) or borrow-out (subtract).
REQ-010 LAST  output  1: combinational; 1 when bit position = WIDTH-1 and EN=1.
REQ-011 RESULT  output  WIDTH: registered parallel copy of the most recently completed result word.
REQ-012 RVALID  output  1: registered one-cycle pulse when RESULT updates.
REQ-013 RV  output  1: registered copy of V for the word held in RESULT.

Function
REQ-014 State: bit counter POS (0..WIDTH-1), carry/borrow bit C, latched mode MQ, and shift register SR (WIDTH-1 bits).
REQ-015 Bit k of K at the current POS is Kb = K[POS].
REQ-016 Add mode: S = X^Kb^C; next C = majority(X,Kb,C).
REQ-017 Subtract mode: S = X^Kb^C; next C = (~X&Kb) | (~(X^Kb)&C), the borrow.
REQ-018 At POS=0 the effective carry-in is 0 and the effective mode is MODE, not MQ; MQ <= MODE on that edge when EN=1.
REQ-019 At POS>0 the effective mode is MQ; MODE changes mid-word are ignored.
REQ-020 V = next C when POS=WIDTH-1 and EN=1; otherwise V = 0.
REQ-021 S is driven for every cycle; it is meaningful only when EN=1.
REQ-022 On an edge with EN=1: POS increments and wraps from WIDTH-1 to 0; C updates; S shifts into SR.
REQ-023 On an edge with EN=0: POS, C, MQ, SR and RESULT hold; RVALID = 0.
REQ-024 On an edge with EN=1 and POS=WIDTH-1: RESULT <= {S, SR} (S becomes the MSB); RV <= V; RVALID <= 1 for exactly that next cycle; C is cleared to 0.
REQ-025 Back-to-back words with no idle cycle are supported; the next word's bit 0 is consumed on the edge after LAST.
REQ-026 Latency: S and V are zero-cycle (same cycle as X); RESULT and RVALID appear one cycle after the LAST edge.
REQ-027 K=0: S = X, V = 0 in both modes.
REQ-028 Behaviour with WIDTH=4, K=3, MODE=0 is bit-exact to the team's fixed serial plus-3 converter, with V as carry-out.

Reset
REQ-029 RST_N=0 immediately sets POS=0, C=0, MQ=0, SR=0, RESULT=0, RV=0, RVALID=0, independent of CLK.
REQ-030 With RST_N=0, S = X and V = 0; LAST = 0.
REQ-031 Reset asserted mid-word discards the partial word; after release, the next EN=1 bit is bit 0.
REQ-032 Release of RST_N is synchronised externally; the block requires no EN=1 on the release edge.

Verification
REQ-033 Default parameters, MODE=0, word 0101 (bits 1,0,1,0) -> S bits 0,0,0,1, V=0; RESULT=1000, RV=0, RVALID pulse.
REQ-034 MODE=0, word 1101 (13) -> S bits 0,0,0,0, V=1 on LAST; RESULT=0000, RV=1.
REQ-035 MODE=1, word 0010 -> RESULT=1111, RV=1 (borrow); word 0111 -> RESULT=0100, RV=0.
REQ-036 Word 0101 with EN=0 for 2 cycles after bit 1, and MODE toggled during the gap -> RESULT=1000, RVALID once, no mode change.
REQ-037 RST_N pulsed low after 2 bits, then full word 0000 -> RESULT=0011, RV=0; no stale RVALID.
REQ-038 WIDTH=8, K=200, MODE=0, 100 then 60 back-to-back -> RESULT=44 (RV=1), then 4 (RV=1); exhaustive random vs reference model for both modes.
